// File: rtl/scalar_mat_op_initiator.sv
// Initiator-side sequencer for scalar-matrix FP units: buffers a row-major frame, runs the unit,
// and re-serialises the result. Optional timeout watchdog enabled by `define SMOI_TIMEOUT_EN.
`timescale 1ns/1ps
module scalar_mat_op_initiator #(
  parameter int unsigned SIZE_A  = 8,
  parameter int unsigned SIZE_B  = 8,
  parameter int unsigned LATENCY = 7,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_data_i,
  input  logic [63:0] in_scale_i,
  output logic        op_start_o,
  output logic [63:0] op_scale_o,
  output logic [63:0] op_mat_o [SIZE_A][SIZE_B],
  input  logic [63:0] op_mat_in_i [SIZE_A][SIZE_B],
  input  logic        op_f_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned N     = SIZE_A * SIZE_B;
  localparam int unsigned IdxW  = $clog2(N + 1);
  localparam int unsigned AddrW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [15:0]     LatCnt  = 16'(LATENCY);

  typedef enum logic [1:0] {StLoad, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            op_start_q, op_start_d;
  logic [63:0]     scale_q, scale_d;
  logic [63:0]     mat_q [N];
  logic [63:0]     mat_d [N];
  logic [63:0]     res_q [N];
  logic [63:0]     res_d [N];
  logic [63:0]     mat_in_flat [N];
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;

  logic [IdxW-1:0]  idx_inc;
  logic [AddrW-1:0] addr;
  logic [AddrW-1:0] addr_inc;

  assign idx_inc  = idx_q + 1'b1;
  assign addr     = idx_q[AddrW-1:0];
  assign addr_inc = idx_inc[AddrW-1:0];

  // Matrices are held flat in row-major order; map to/from the 2-D ports here.
  for (genvar r = 0; r < SIZE_A; r++) begin : g_row
    for (genvar c = 0; c < SIZE_B; c++) begin : g_col
      assign op_mat_o[r][c]           = mat_q[r*SIZE_B+c];
      assign mat_in_flat[r*SIZE_B+c]  = op_mat_in_i[r][c];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    op_start_d  = op_start_q;
    scale_d     = scale_q;
    mat_d       = mat_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    unique case (state_q)
      StLoad: begin
        if (in_valid_i) begin
          mat_d[addr] = in_data_i;
          if (idx_q == '0) scale_d = in_scale_i;
          if (idx_q == LastIdx) begin
            idx_d      = '0;
            wcnt_d     = '0;
            op_start_d = 1'b1;
            state_d    = StRun;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      StRun: begin
        if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        // An op_f that arrives before the unit latency has elapsed is not trusted.
        if (op_f_i && (wcnt_q >= LatCnt)) begin
          res_d       = mat_in_flat;
          op_start_d  = 1'b0;
          wcnt_d      = '0;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = mat_in_flat[0];
          out_last_d  = (LastIdx == '0);
          state_d     = StDrain;
        end
`ifdef SMOI_TIMEOUT_EN
        else if (wcnt_q >= 16'(TIMEOUT)) begin
          err_d      = 1'b1;
          op_start_d = 1'b0;
          wcnt_d     = '0;
          idx_d      = '0;
          state_d    = StLoad;
        end
`endif
      end

      StDrain: begin
        if (out_ready_i) begin
          if (idx_q == LastIdx) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
            state_d     = StLoad;
          end else begin
            idx_d      = idx_inc;
            out_data_d = res_q[addr_inc];
            out_last_d = (idx_inc == LastIdx);
          end
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      wcnt_q      <= '0;
      op_start_q  <= 1'b0;
      scale_q     <= '0;
      mat_q       <= '{default: '0};
      res_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      op_start_q  <= op_start_d;
      scale_q     <= scale_d;
      mat_q       <= mat_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

`ifndef SMOI_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^(16'(TIMEOUT));
`endif

  assign in_ready_o  = (state_q == StLoad);
  assign busy_o      = (state_q != StLoad);
  assign op_start_o  = op_start_q;
  assign op_scale_o  = scale_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_scalar_mat_op_initiator.sv
// Directed bench for scalar_mat_op_initiator on a 2x2 frame with a behavioural subtract unit.
`timescale 1ns/1ps
module tb_scalar_mat_op_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_data, in_scale;
  logic        op_start;
  logic [63:0] op_scale;
  logic [63:0] op_mat [2][2];
  logic [63:0] op_mat_in [2][2];
  logic        op_f;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int f_mode = 0;  // 0: op_f after 7 cycles, 1: op_f immediately, 2: never
  int run_cnt = 0;

  always #5 clk = ~clk;

  scalar_mat_op_initiator #(
    .SIZE_A(2), .SIZE_B(2), .LATENCY(7), .TIMEOUT(20)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_scale_i (in_scale),
    .op_start_o (op_start),
    .op_scale_o (op_scale),
    .op_mat_o   (op_mat),
    .op_mat_in_i(op_mat_in),
    .op_f_i     (op_f),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Behavioural subtract unit: result is only meaningful after 7 enabled cycles.
  always @(posedge clk) begin
    if (op_start) run_cnt <= run_cnt + 1;
    else          run_cnt <= 0;
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        op_mat_in[r][c] = (run_cnt >= 7) ?
          $realtobits($bitstoreal(op_mat[r][c]) - $bitstoreal(op_scale)) :
          64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
    op_f = 1'b0;
    if (f_mode == 0)      op_f = op_start && (run_cnt >= 7);
    else if (f_mode == 1) op_f = op_start;
  end

  localparam logic [63:0] D0_5 = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] D1_0 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D1_5 = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] D2_0 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D2_5 = 64'h4004_0000_0000_0000;
  localparam logic [63:0] D3_0 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D3_5 = 64'h400C_0000_0000_0000;
  localparam logic [63:0] D4_0 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D5_0 = 64'h4014_0000_0000_0000;
  localparam logic [63:0] D6_0 = 64'h4018_0000_0000_0000;
  localparam logic [63:0] D7_0 = 64'h401C_0000_0000_0000;
  localparam logic [63:0] D8_0 = 64'h4020_0000_0000_0000;
  localparam logic [63:0] D9_0 = 64'h4022_0000_0000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_scale = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [63:0] d3, input logic [63:0] s);
    send(d0, s);
    send(d1, s);
    send(d2, s);
    send(d3, s);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check1({tag, "_valid_seen"}, out_valid, 1'b1);
  endtask

  task automatic count_start(output int cnt);
    cnt = 0;
    while (op_start && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic drain4(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                        input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b1;
    wait_valid(tag);
    for (int i = 0; i < 4; i++) begin
      check64($sformatf("%s_data%0d", tag, i), out_data, e[i]);
      check1($sformatf("%s_last%0d", tag, i), out_last, (i == 3));
      tick();
    end
    check1({tag, "_done_valid"}, out_valid, 1'b0);
    check1({tag, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    int beat;
    int pat [7];
    pat = '{1, 0, 0, 1, 0, 1, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_scale = '0; out_ready = 1'b1;
    tick(); tick();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_op_start", op_start, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_out_last", out_last, 1'b0);
    check64("rst_op_scale", op_scale, 64'h0);
    check64("rst_op_mat11", op_mat[1][1], 64'h0);
    check64("rst_out_data", out_data, 64'h0);
    rst_n = 1'b1;
    tick();

    // 1) basic frame, unit finishes after its latency
    f_mode = 0;
    send4(D1_0, D2_0, D3_0, D4_0, D1_0);
    check1("t1_in_ready_run", in_ready, 1'b0);
    check1("t1_busy_run", busy, 1'b1);
    count_start(cnt);
    check_int("t1_start_cycles", cnt, 8);
    drain4("t1", 64'h0, D1_0, D2_0, D3_0);

    // 2) op_f asserted from the first RUN cycle must not cause early capture
    f_mode = 1;
    send4(D1_0, D2_0, D3_0, D4_0, D1_0);
    check64("t2_op_mat11", op_mat[1][1], D4_0);
    check64("t2_op_scale", op_scale, D1_0);
    count_start(cnt);
    check_int("t2_start_cycles", cnt, 8);
    drain4("t2", 64'h0, D1_0, D2_0, D3_0);

    // 3) downstream back-pressure
    f_mode = 0;
    out_ready = 1'b0;
    send4(D1_0, D2_0, D3_0, D4_0, D1_0);
    wait_valid("t3");
    beat = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = (pat[k] != 0);
      check1($sformatf("t3_valid_k%0d", k), out_valid, 1'b1);
      check64($sformatf("t3_data_k%0d", k), out_data,
              (beat == 0) ? 64'h0 : (beat == 1) ? D1_0 : (beat == 2) ? D2_0 : D3_0);
      check1($sformatf("t3_last_k%0d", k), out_last, (beat == 3));
      if (pat[k] != 0) beat++;
      tick();
    end
    check1("t3_done_valid", out_valid, 1'b0);
    check1("t3_done_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // 4) input gaps; scale changes after beat 0 are ignored
    in_valid = 1'b1; in_data = D5_0; in_scale = D2_0; tick();
    in_valid = 1'b0; in_data = 64'hBAD; in_scale = D9_0; tick();
    in_valid = 1'b1; in_data = D6_0; tick();
    in_valid = 1'b0; in_data = 64'hBAD; tick();
    tick();
    in_valid = 1'b1; in_data = D7_0; tick();
    in_data = D8_0; tick();
    in_valid = 1'b0;
    check64("t4_op_mat00", op_mat[0][0], D5_0);
    check64("t4_op_mat01", op_mat[0][1], D6_0);
    check64("t4_op_mat10", op_mat[1][0], D7_0);
    check64("t4_op_mat11", op_mat[1][1], D8_0);
    check64("t4_op_scale", op_scale, D2_0);
    drain4("t4", D3_0, D4_0, D5_0, D6_0);

    // 5) reset in the middle of RUN, then a fresh frame
    send4(D1_0, D2_0, D3_0, D4_0, D1_0);
    tick(); tick(); tick();
    check1("t5_pre_start", op_start, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("t5_rst_op_start", op_start, 1'b0);
    check1("t5_rst_out_valid", out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check1("t5_in_ready", in_ready, 1'b1);
    check1("t5_busy", busy, 1'b0);
    check64("t5_op_scale", op_scale, 64'h0);
    send4(D1_0, D2_0, D3_0, D4_0, D0_5);
    drain4("t5", D0_5, D1_5, D2_5, D3_5);

    // 6) unit never finishes
    f_mode = 2;
    send4(D1_0, D2_0, D3_0, D4_0, D1_0);
`ifdef SMOI_TIMEOUT_EN
    cnt = 0;
    while (!err && cnt < 60) begin
      tick();
      cnt++;
    end
    check1("t6_err", err, 1'b1);
    check1("t6_not_early", (cnt >= 19), 1'b1);
    check1("t6_op_start", op_start, 1'b0);
    check1("t6_in_ready", in_ready, 1'b1);
    check1("t6_out_valid", out_valid, 1'b0);
`else
    repeat (40) tick();
    check1("t6_op_start", op_start, 1'b1);
    check1("t6_err", err, 1'b0);
    check1("t6_out_valid", out_valid, 1'b0);
    check1("t6_busy", busy, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
